falafel_req_arbiter: RTL and testbench

Multi-requester front end for the falafel allocator. It arbitrates round-robin between `NUM_REQ` independent valid/ready request streams and forwards each whole request transaction, without interleaving, onto the single request port of `falafel_input_parser`. It also tags every alloc request with the requester ID so the response path can route results back.

---
 rtl/falafel_pkg.sv | 37 +++
 rtl/falafel_rr_arbiter.sv | 44 ++++
 rtl/falafel_req_arbiter.sv | 132 +++++++++++++
 tb/tb_falafel_req_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/falafel_pkg.sv
// Shared falafel constants and request-command helpers.
// Command decode used by the request arbiter.
package falafel_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] REQ_ACCESS_REGISTER = 32'h0000_0001;
  localparam logic [DATA_W-1:0] REQ_ALLOC_MEM       = 32'h0000_0002;
  localparam logic [DATA_W-1:0] REQ_FREE_MEM        = 32'h0000_0003;

  function automatic logic [1:0] req_len_m1(
    logic [DATA_W-1:0] cmd
  );
    logic [1:0] len;
    case (cmd)
      REQ_ACCESS_REGISTER: len = 2'd2;
      REQ_ALLOC_MEM:       len = 2'd1;
      REQ_FREE_MEM:        len = 2'd1;
      default:             len = 2'd0;
    endcase
    return len;
  endfunction

  function automatic logic req_cmd_known(
    logic [DATA_W-1:0] cmd
  );
    logic known;
    case (cmd)
      REQ_ACCESS_REGISTER: known = 1'b1;
      REQ_ALLOC_MEM:       known = 1'b1;
      REQ_FREE_MEM:        known = 1'b1;
      default:             known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/falafel_rr_arbiter.sv
// Combinational round-robin pick: first request
// at or after ptr_i, wrapping modulo NUM_REQ.
module falafel_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               gnt_val_o,
  output logic [ID_W-1:0]    gnt_id_o
);

  localparam logic [ID_W:0] NR = (ID_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    enc;
  logic [ID_W:0]      sum;

  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = i + int'(ptr_i);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      rot[i] = req_i[idx];
    end
  end

  always_comb begin
    enc = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = ID_W'(i);
    end
  end

  always_comb begin
    sum = {1'b0, ptr_i} + {1'b0, enc};
    if (sum >= NR) sum = sum - NR;
  end

  assign gnt_val_o = |req_i;
  assign gnt_id_o  = sum[ID_W-1:0];

endmodule

// File: rtl/falafel_req_arbiter.sv
// Round-robin front end: forwards whole request
// transactions from NUM_REQ ports to the parser.
module falafel_req_arbiter
  import falafel_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_val_i,
  output logic [NUM_REQ-1:0]             req_rdy_o,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i,
  output logic                           out_val_o,
  input  logic                           out_rdy_i,
  output logic [DATA_W-1:0]              out_data_o,
  output logic                           busy_o,
  output logic [ID_W-1:0]                gnt_id_o,
  output logic                           alloc_issue_o,
  output logic [ID_W-1:0]                alloc_issue_id_o,
  output logic                           bad_cmd_o
);

  typedef enum logic {
    STATE_IDLE,
    STATE_XFER
  } arb_state_e;

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0]      words_left_q, words_left_d;
  logic            first_q, first_d;
  logic            is_alloc_q, is_alloc_d;

  logic              arb_val;
  logic [ID_W-1:0]   arb_id;
  logic              cur_val;
  logic [DATA_W-1:0] cur_data;
  logic              hs;
  logic [ID_W-1:0]   ptr_nxt;

  falafel_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i     (req_val_i),
    .ptr_i     (rr_ptr_q),
    .gnt_val_o (arb_val),
    .gnt_id_o  (arb_id)
  );

  assign cur_val  = req_val_i[gnt_id_q];
  assign cur_data = req_data_i[gnt_id_q];
  assign hs       = cur_val & out_rdy_i;
  assign ptr_nxt  = (gnt_id_q == ID_W'(NUM_REQ - 1))
                  ? '0 : gnt_id_q + ID_W'(1);

  always_comb begin
    state_d       = state_q;
    gnt_id_d      = gnt_id_q;
    rr_ptr_d      = rr_ptr_q;
    words_left_d  = words_left_q;
    first_d       = first_q;
    is_alloc_d    = is_alloc_q;
    req_rdy_o     = '0;
    out_val_o     = 1'b0;
    out_data_o    = '0;
    alloc_issue_o = 1'b0;
    bad_cmd_o     = 1'b0;
    unique case (state_q)
      STATE_IDLE: begin
        if (arb_val) begin
          gnt_id_d = arb_id;
          first_d  = 1'b1;
          state_d  = STATE_XFER;
        end
      end
      STATE_XFER: begin
        out_data_o = cur_data;
        if (first_q && !req_cmd_known(cur_data)) begin
          // swallow the bad word; the parser never sees it
          req_rdy_o[gnt_id_q] = 1'b1;
          if (cur_val) begin
            bad_cmd_o = 1'b1;
            state_d   = STATE_IDLE;
            rr_ptr_d  = ptr_nxt;
          end
        end else begin
          out_val_o           = cur_val;
          req_rdy_o[gnt_id_q] = out_rdy_i;
          if (hs && first_q) begin
            words_left_d = req_len_m1(cur_data);
            first_d      = 1'b0;
            is_alloc_d   = (cur_data == REQ_ALLOC_MEM);
          end else if (hs) begin
            words_left_d = words_left_q - 2'd1;
            if (words_left_q == 2'd1) begin
              state_d       = STATE_IDLE;
              rr_ptr_d      = ptr_nxt;
              alloc_issue_o = is_alloc_q;
            end
          end
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= STATE_IDLE;
      gnt_id_q     <= '0;
      rr_ptr_q     <= '0;
      words_left_q <= '0;
      first_q      <= 1'b0;
      is_alloc_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_id_q     <= gnt_id_d;
      rr_ptr_q     <= rr_ptr_d;
      words_left_q <= words_left_d;
      first_q      <= first_d;
      is_alloc_q   <= is_alloc_d;
    end
  end

  assign busy_o           = (state_q == STATE_XFER);
  assign gnt_id_o         = gnt_id_q;
  assign alloc_issue_id_o = gnt_id_q;

endmodule

// File: tb/tb_falafel_req_arbiter.sv
// Directed bench for falafel_req_arbiter with
// per-port word queues as requesters.
module tb_falafel_req_arbiter;
  import falafel_pkg::*;

  localparam int N = 4;

  logic                     clk;
  logic                     rst_n;
  logic [N-1:0]             req_val;
  logic [N-1:0]             req_rdy;
  logic [N-1:0][DATA_W-1:0] req_data;
  logic                     out_val;
  logic                     out_rdy;
  logic [DATA_W-1:0]        out_data;
  logic                     busy;
  logic [1:0]               gnt_id;
  logic                     alloc_issue;
  logic [1:0]               alloc_id;
  logic                     bad_cmd;

  falafel_req_arbiter #(.NUM_REQ(N)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_val_i        (req_val),
    .req_rdy_o        (req_rdy),
    .req_data_i       (req_data),
    .out_val_o        (out_val),
    .out_rdy_i        (out_rdy),
    .out_data_o       (out_data),
    .busy_o           (busy),
    .gnt_id_o         (gnt_id),
    .alloc_issue_o    (alloc_issue),
    .alloc_issue_id_o (alloc_id),
    .bad_cmd_o        (bad_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] wq [N][8];
  int          wlen [N];
  int          widx [N];
  logic [N-1:0] hold;
  int total;
  int passed;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
  endtask

  task automatic upd();
    for (int p = 0; p < N; p++) begin
      if (!hold[p] && widx[p] < wlen[p]) begin
        req_val[p]  = 1'b1;
        req_data[p] = wq[p][widx[p]];
      end else begin
        req_val[p]  = 1'b0;
        req_data[p] = '0;
      end
    end
  endtask

  task automatic nxt();
    logic [N-1:0] hs;
    hs = req_val & req_rdy;
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++)
      if (hs[p]) widx[p] = widx[p] + 1;
    upd();
  endtask

  task automatic load(input int p,
                      input logic [31:0] w0,
                      input logic [31:0] w1,
                      input logic [31:0] w2,
                      input logic [31:0] w3,
                      input int n);
    wq[p][0] = w0;
    wq[p][1] = w1;
    wq[p][2] = w2;
    wq[p][3] = w3;
    wlen[p]  = n;
    widx[p]  = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold  = '0;
    for (int p = 0; p < N; p++) begin
      wlen[p] = 0;
      widx[p] = 0;
    end
    upd();
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_val", 64'(out_val), 64'd0);
    chk("rst_rdy", 64'(req_rdy), 64'd0);
    chk("rst_gnt", 64'(gnt_id), 64'd0);
    chk("rst_alloc", 64'(alloc_issue), 64'd0);
    chk("rst_bad", 64'(bad_cmd), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] t3d [6];
    total   = 0;
    passed  = 0;
    out_rdy = 1'b1;
    req_val = '0;
    req_data = '0;
    do_reset();

    // single ALLOC from port 1
    load(1, REQ_ALLOC_MEM, 32'h40, 0, 0, 2);
    upd();
    #1;
    chk("a0_busy", 64'(busy), 64'd0);
    chk("a0_rdy", 64'(req_rdy), 64'd0);
    nxt(); #1;
    chk("a1_gnt", 64'(gnt_id), 64'd1);
    chk("a1_val", 64'(out_val), 64'd1);
    chk("a1_data", 64'(out_data), 64'(REQ_ALLOC_MEM));
    chk("a1_rdy", 64'(req_rdy), 64'b0010);
    chk("a1_alloc", 64'(alloc_issue), 64'd0);
    nxt(); #1;
    chk("a2_data", 64'(out_data), 64'h40);
    chk("a2_alloc", 64'(alloc_issue), 64'd1);
    chk("a2_id", 64'(alloc_id), 64'd1);
    nxt(); #1;
    chk("a3_busy", 64'(busy), 64'd0);
    chk("a3_alloc", 64'(alloc_issue), 64'd0);

    // REG on port 2 with toggling out_rdy, ptr now 2
    load(0, REQ_FREE_MEM, 32'hA0, 0, 0, 2);
    load(2, REQ_ACCESS_REGISTER, 32'h3, 32'h80, 0, 3);
    load(3, REQ_FREE_MEM, 32'hA3, 0, 0, 2);
    upd();
    #1;
    chk("r0_val", 64'(out_val), 64'd0);
    chk("r0_rdy", 64'(req_rdy), 64'd0);
    t3d[0] = REQ_ACCESS_REGISTER;
    t3d[1] = REQ_ACCESS_REGISTER;
    t3d[2] = 32'h3;
    t3d[3] = 32'h3;
    t3d[4] = 32'h80;
    t3d[5] = 32'h80;
    for (int k = 0; k < 6; k++) begin
      nxt();
      out_rdy = (k % 2 == 1);
      #1;
      chk("r_gnt", 64'(gnt_id), 64'd2);
      chk("r_data", 64'(out_data), 64'(t3d[k]));
      chk("r_rdy", 64'(req_rdy),
          (k % 2 == 1) ? 64'b0100 : 64'd0);
    end
    out_rdy = 1'b1;
    nxt(); #1;
    chk("r7_busy", 64'(busy), 64'd0);
    nxt(); #1;
    chk("r8_gnt", 64'(gnt_id), 64'd3);
    chk("r8_data", 64'(out_data), 64'(REQ_FREE_MEM));

    // all ports FREE continuously from ptr 0
    do_reset();
    for (int p = 0; p < N; p++)
      load(p, REQ_FREE_MEM, 32'h100 + 32'(p),
           REQ_FREE_MEM, 32'h110 + 32'(p), 4);
    upd();
    for (int t = 0; t < 5; t++) begin
      #1;
      chk("f_idle", 64'(busy), 64'd0);
      nxt(); #1;
      chk("f_gnt", 64'(gnt_id), 64'(t % 4));
      chk("f_cmd", 64'(out_data), 64'(REQ_FREE_MEM));
      chk("f_rdy", 64'(req_rdy), 64'(1 << (t % 4)));
      nxt(); #1;
      chk("f_pay", 64'(out_data),
          64'(32'h100 + 32'((t / 4) * 16 + t % 4)));
      nxt();
    end

    // unknown command on port 0
    do_reset();
    load(0, 32'hDEAD, 0, 0, 0, 1);
    load(1, REQ_FREE_MEM, 32'h11, 0, 0, 2);
    upd();
    nxt(); #1;
    chk("b1_val", 64'(out_val), 64'd0);
    chk("b1_rdy", 64'(req_rdy), 64'b0001);
    chk("b1_bad", 64'(bad_cmd), 64'd1);
    nxt(); #1;
    chk("b2_busy", 64'(busy), 64'd0);
    chk("b2_bad", 64'(bad_cmd), 64'd0);
    nxt(); #1;
    chk("b3_gnt", 64'(gnt_id), 64'd1);
    chk("b3_data", 64'(out_data), 64'(REQ_FREE_MEM));
    chk("b3_bad", 64'(bad_cmd), 64'd0);

    // port 3 stalls mid-transaction
    do_reset();
    load(3, REQ_FREE_MEM, 32'h55, 0, 0, 2);
    upd();
    nxt(); #1;
    chk("s1_gnt", 64'(gnt_id), 64'd3);
    for (int k = 0; k < 5; k++) begin
      nxt();
      if (k == 0) begin
        hold[3] = 1'b1;
        load(0, REQ_FREE_MEM, 32'h66, 0, 0, 2);
        upd();
      end
      #1;
      chk("s_busy", 64'(busy), 64'd1);
      chk("s_gnt", 64'(gnt_id), 64'd3);
      chk("s_val", 64'(out_val), 64'd0);
      chk("s_rdy", 64'(req_rdy), 64'b1000);
    end
    nxt();
    hold[3] = 1'b0;
    upd();
    #1;
    chk("s7_data", 64'(out_data), 64'h55);
    chk("s7_val", 64'(out_val), 64'd1);
    nxt(); #1;
    chk("s8_busy", 64'(busy), 64'd0);
    nxt(); #1;
    chk("s9_gnt", 64'(gnt_id), 64'd0);

    // reset after the cmd word of an ALLOC
    do_reset();
    load(0, REQ_ALLOC_MEM, 32'h77, 0, 0, 2);
    upd();
    nxt(); #1;
    chk("m1_data", 64'(out_data), 64'(REQ_ALLOC_MEM));
    nxt();
    do_reset();
    load(0, REQ_ALLOC_MEM, 32'h99, 0, 0, 2);
    upd();
    #1;
    chk("m0_busy", 64'(busy), 64'd0);
    nxt(); #1;
    chk("m1_cmd", 64'(out_data), 64'(REQ_ALLOC_MEM));
    chk("m1_alloc", 64'(alloc_issue), 64'd0);
    nxt(); #1;
    chk("m2_data", 64'(out_data), 64'h99);
    chk("m2_alloc", 64'(alloc_issue), 64'd1);
    chk("m2_id", 64'(alloc_id), 64'd0);
    nxt(); #1;
    chk("m3_busy", 64'(busy), 64'd0);
    chk("m3_alloc", 64'(alloc_issue), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
